// File: rtl/nios_system_sram_port_arbiter_if.sv
// Avalon-MM requester bundle for one side of the SRAM port-2 arbiter.
// master = requester view, slave = arbiter view.
interface nios_system_sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sram_port_arbiter.sv
// Round-robin arbiter sharing SRAM port 2 between two Avalon-MM requesters,
// with a built-in sequencer that fills the whole memory with CLEAR_VALUE.
module nios_system_sram_port_arbiter #(
  parameter int unsigned       ADDR_W      = 11,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       BE_W        = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  nios_system_sram_port_arbiter_if.slave m0,
  nios_system_sram_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [BE_W-1:0]            mem_byteenable,
  output logic                       mem_chipselect,
  output logic                       mem_write,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic                       mem_clken,
  input  logic [DATA_W-1:0]          mem_readdata,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [1:0]        rd_owner_q, rd_owner_d;  // one-hot: bit N = requester N
  logic              req0, req1, arb_en, gnt0, gnt1;

  assign req0   = m0.read | m0.write;
  assign req1   = m1.read | m1.write;
  assign arb_en = (state_q == StIdle);

  // On a tie the requester that was not granted last wins.
  assign gnt0 = arb_en & req0 & (~req1 | last_q);
  assign gnt1 = arb_en & req1 & (~req0 | ~last_q);

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_owner_q[0];
  assign m1.readdatavalid = rd_owner_q[1];

  assign mem_clken  = 1'b1;
  assign clear_busy = (state_q != StIdle);
  assign clear_done = (state_q == StDone);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (state_q == StClear) begin
      mem_address    = cnt_q;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_writedata  = CLEAR_VALUE;
    end else if (gnt0) begin
      mem_address    = m0.address;
      mem_byteenable = m0.byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m0.write;
      mem_writedata  = m0.writedata;
    end else if (gnt1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_chipselect = 1'b1;
      mem_write      = m1.write;
      mem_writedata  = m1.writedata;
    end
  end

  always_comb begin
    last_d     = last_q;
    rd_owner_d = {gnt1 & m1.read & ~m1.write, gnt0 & m0.read & ~m0.write};
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      rd_owner_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_nios_system_sram_port_arbiter.sv
// Directed bench for the SRAM port-2 arbiter with a behavioural port-2 SRAM
// (registered address, unregistered read data).
module tb_nios_system_sram_port_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_init;

  int n_checks = 0;
  int n_errors = 0;

  nios_system_sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
  nios_system_sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();

  nios_system_sram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BE_W        (BE_W),
    .CLEAR_VALUE (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .clear_req      (clear_req),
    .clear_busy     (clear_busy),
    .clear_done     (clear_done)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [2048];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) sram[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) sram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= sram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0;
    m0_bus.byteenable = '0; m0_bus.writedata = '0;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0;
    m1_bus.byteenable = '0; m1_bus.writedata = '0;
    clear_req = 1'b0;
  endtask

  task automatic drive(input bit m, input bit wr, input logic [10:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m) begin
      m1_bus.read = ~wr; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.byteenable = be; m1_bus.writedata = d;
    end else begin
      m0_bus.read = ~wr; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.byteenable = be; m0_bus.writedata = d;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle later.
  task automatic wr(input bit m, input logic [10:0] a, input logic [3:0] be,
                    input logic [31:0] d, input string tag);
    drive(m, 1'b1, a, be, d);
    #1;
    check({tag, "_wait"}, m ? m1_bus.waitrequest : m0_bus.waitrequest, 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'(a));
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic rd_check(input bit m, input logic [10:0] a, input logic [31:0] exp,
                          input string tag);
    drive(m, 1'b0, a, 4'hF, 32'h0);
    #1;
    check({tag, "_wait"}, m ? m1_bus.waitrequest : m0_bus.waitrequest, 32'd0);
    @(posedge clk); #1;
    idle_all();
    check({tag, "_rdv"}, m ? m1_bus.readdatavalid : m0_bus.readdatavalid, 32'd1);
    check({tag, "_other_rdv"}, m ? m0_bus.readdatavalid : m1_bus.readdatavalid, 32'd0);
    check({tag, "_data"}, m ? m1_bus.readdata : m0_bus.readdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_all();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  int n0, n1, busy_cnt, done_cnt, done_at, wait_bad, guard;

  initial begin
    reset_n  = 1'b0;
    mem_init = 1'b1;
    idle_all();
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    check("rst_rdv0", 32'(m0_bus.readdatavalid), 32'd0);
    check("rst_rdv1", 32'(m1_bus.readdatavalid), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    reset_n = 1'b1;
    #1;
    check("idle_cs", 32'(mem_chipselect), 32'd0);
    check("idle_clken", 32'(mem_clken), 32'd1);
    @(posedge clk); #1;

    // Single-requester write then read-back
    wr(1'b0, 11'd5, 4'hF, 32'hDEAD_BEEF, "m0_wr5");
    rd_check(1'b0, 11'd5, 32'hDEAD_BEEF, "m0_rd5");

    // Both reading continuously: grants alternate starting with m0
    do_reset();
    drive(1'b0, 1'b0, 11'h10, 4'hF, 32'h0);
    drive(1'b1, 1'b0, 11'h20, 4'hF, 32'h0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("alt_wait0_%0d", k), 32'(m0_bus.waitrequest), 32'(k % 2));
      check($sformatf("alt_wait1_%0d", k), 32'(m1_bus.waitrequest), 32'((k + 1) % 2));
      @(posedge clk); #1;
      if (m0_bus.readdatavalid) begin
        n0++;
        check("alt_data0", m0_bus.readdata, 32'hA500_0010);
      end
      if (m1_bus.readdatavalid) begin
        n1++;
        check("alt_data1", m1_bus.readdata, 32'hA500_0020);
      end
    end
    idle_all();
    check("alt_cnt0", 32'(n0), 32'd4);
    check("alt_cnt1", 32'(n1), 32'd4);
    @(posedge clk); #1;

    // Partial byte-enable write over a full-word write
    wr(1'b1, 11'd7, 4'hF, 32'hFFFF_FFFF, "m1_wr7a");
    wr(1'b1, 11'd7, 4'h3, 32'h1122_3344, "m1_wr7b");
    rd_check(1'b1, 11'd7, 32'hFFFF_3344, "m1_rd7");

    // Full clear with m0 requesting throughout; a read accepted with clear_req returns
    drive(1'b0, 1'b0, 11'd5, 4'hF, 32'h0);
    clear_req = 1'b1;
    #1;
    check("clr_req_wait0", 32'(m0_bus.waitrequest), 32'd0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    check("clr_busy_rise", 32'(clear_busy), 32'd1);
    check("clr_pre_rdv", 32'(m0_bus.readdatavalid), 32'd1);
    check("clr_pre_data", m0_bus.readdata, 32'hDEAD_BEEF);
    busy_cnt = 0; done_cnt = 0; done_at = 0; wait_bad = 0; guard = 0;
    while (clear_busy && guard < 3000) begin
      busy_cnt++;
      if (!m0_bus.waitrequest) wait_bad++;
      if (clear_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      clear_req = (busy_cnt == 10);
      @(posedge clk); #1;
      guard++;
    end
    clear_req = 1'b0;
    check("clr_busy_len", 32'(busy_cnt), 32'd2049);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);
    check("clr_done_at", 32'(done_at), 32'd2049);
    check("clr_wait_held", 32'(wait_bad), 32'd0);
    check("clr_after_wait0", 32'(m0_bus.waitrequest), 32'd0);
    idle_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd_check(1'b0, 11'd0, 32'h0, "clr_rd0");
    rd_check(1'b1, 11'd1023, 32'h0, "clr_rd1023");
    rd_check(1'b0, 11'd2047, 32'h0, "clr_rd2047");

    // Reset in the middle of a clear
    wr(1'b0, 11'd99, 4'hF, 32'h1234_5678, "pre_wr99");
    wr(1'b0, 11'd101, 4'hF, 32'hCAFE_F00D, "pre_wr101");
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(clear_busy), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_after", 32'(clear_busy), 32'd0);
    rd_check(1'b0, 11'd99, 32'h0, "abort_rd99");
    rd_check(1'b1, 11'd101, 32'hCAFE_F00D, "abort_rd101");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
